// File: rtl/tag_nios_pio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tag_nios_pio_irq
// Purpose  : Parametrised Avalon-MM general-purpose I/O port with per-bit
//            direction, atomic output set/clear, synchronised inputs with
//            edge capture and a maskable level interrupt.
// Ports    : i_clk, i_reset        - clock, asynchronous active-high reset
//            i_address[2:0]        - register select
//            i_chipselect          - slave select
//            i_read_n, i_write_n   - active-low read / write strobes
//            i_writedata[31:0]     - write data
//            o_readdata[31:0]      - registered read data (latency 1)
//            i_in_port[WIDTH-1:0]  - pin inputs (asynchronous to i_clk)
//            o_out_port[WIDTH-1:0] - output data register
//            o_oe[WIDTH-1:0]       - per-bit output enable (direction)
//            o_irq                 - level interrupt, active high
// Revision : 1.0 - initial release
// ============================================================================
module tag_nios_pio_irq #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] DIR_RESET   = '0,
   parameter int unsigned      EDGE_TYPE   = 0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [2:0]       i_address,
   input  logic             i_chipselect,
   input  logic             i_read_n,
   input  logic             i_write_n,
   input  logic [31:0]      i_writedata,
   output logic [31:0]      o_readdata,
   input  logic [WIDTH-1:0] i_in_port,
   output logic [WIDTH-1:0] o_out_port,
   output logic [WIDTH-1:0] o_oe,
   output logic             o_irq
);

   localparam logic [2:0] c_ADDR_DATA    = 3'd0;
   localparam logic [2:0] c_ADDR_DIR     = 3'd1;
   localparam logic [2:0] c_ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] c_ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] c_ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] c_ADDR_OUTCLR  = 3'd5;

   logic [WIDTH-1:0] r_data_out;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] r_edgecap;
   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_prev;
   logic [1:0]       r_warm_cnt;
   logic [31:0]      r_readdata;

   logic             w_wr;
   logic             w_rd;
   logic [WIDTH-1:0] w_wdata;
   logic             w_warm;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_capture;
   logic [WIDTH-1:0] w_cap_clr;
   logic [31:0]      w_rd_mux;
   logic             w_unused_wdata;

   assign w_wr    = i_chipselect & ~i_write_n;
   assign w_rd    = i_chipselect & ~i_read_n;
   assign w_wdata = i_writedata[WIDTH-1:0];
   // Upper write-data bits are deliberately ignored when WIDTH < 32.
   assign w_unused_wdata = ^i_writedata;

   // ------------------------------------------------------------------------
   // Input synchroniser, history flop and warm-up counter. The sync flops
   // reset to 0, so a pin held high through reset would look like a rising
   // edge; edge detection stays off until the counter saturates.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_prev     <= '0;
         r_warm_cnt <= 2'd0;
      end else begin
         r_sync1 <= i_in_port;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (r_warm_cnt != 2'd3)
            r_warm_cnt <= r_warm_cnt + 2'd1;
      end
   end

   assign w_warm = (r_warm_cnt == 2'd3);

   always_comb begin
      w_edge = '0;
      case (EDGE_TYPE)
         0:       w_edge = r_sync2 & ~r_prev;
         1:       w_edge = ~r_sync2 & r_prev;
         default: w_edge = r_sync2 ^ r_prev;
      endcase
   end

   // Only input bits (direction = 0) capture edges.
   assign w_capture = w_edge & ~r_dir & {WIDTH{w_warm}};
   assign w_cap_clr = (w_wr && (i_address == c_ADDR_EDGECAP)) ? w_wdata : '0;

   // ------------------------------------------------------------------------
   // Control/status registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_data_out <= RESET_VALUE;
         r_dir      <= DIR_RESET;
         r_irqmask  <= '0;
         r_edgecap  <= '0;
      end else begin
         if (w_wr) begin
            case (i_address)
               c_ADDR_DATA:    r_data_out <= w_wdata;
               c_ADDR_DIR:     r_dir      <= w_wdata;
               c_ADDR_IRQMASK: r_irqmask  <= w_wdata;
               c_ADDR_OUTSET:  r_data_out <= r_data_out | w_wdata;
               c_ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wdata;
               default: ;
            endcase
         end
         // A new edge in the same cycle as a write-1-clear keeps the bit set.
         r_edgecap <= (r_edgecap & ~w_cap_clr) | w_capture;
      end
   end

   // ------------------------------------------------------------------------
   // Read path: sampled from pre-write register values, zero-extended.
   // ------------------------------------------------------------------------
   always_comb begin
      w_rd_mux = '0;
      case (i_address)
         c_ADDR_DATA:    w_rd_mux[WIDTH-1:0] = r_sync2;
         c_ADDR_DIR:     w_rd_mux[WIDTH-1:0] = r_dir;
         c_ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
         c_ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
         default:        w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_readdata <= '0;
      else if (w_rd)
         r_readdata <= w_rd_mux;
   end

   assign o_readdata = r_readdata;
   assign o_out_port = r_data_out;
   assign o_oe       = r_dir;
   assign o_irq      = |(r_edgecap & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_tag_nios_pio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tag_nios_pio_irq
// Purpose  : Self-checking bench for tag_nios_pio_irq (WIDTH=8). A rising-edge
//            instance and an any-edge instance share the same bus and pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tag_nios_pio_irq;

   logic        clk;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;

   logic [31:0] rd1, rd2;
   logic [7:0]  out1, out2, oe1, oe2;
   logic        irq1, irq2;

   int n_vec;
   int n_bad;

   tag_nios_pio_irq #(.WIDTH(8), .EDGE_TYPE(0)) dut (
      .i_clk(clk), .i_reset(reset), .i_address(address),
      .i_chipselect(chipselect), .i_read_n(read_n), .i_write_n(write_n),
      .i_writedata(writedata), .o_readdata(rd1), .i_in_port(in_port),
      .o_out_port(out1), .o_oe(oe1), .o_irq(irq1)
   );

   tag_nios_pio_irq #(.WIDTH(8), .EDGE_TYPE(2)) dut_any (
      .i_clk(clk), .i_reset(reset), .i_address(address),
      .i_chipselect(chipselect), .i_read_n(read_n), .i_write_n(write_n),
      .i_writedata(writedata), .o_readdata(rd2), .i_in_port(in_port),
      .o_out_port(out2), .o_oe(oe2), .o_irq(irq2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_wr;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [7:0]  pins;
      logic [7:0]  exp_out;
      logic [7:0]  exp_oe;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_rd(input logic [2:0] a);
      @(negedge clk);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0; n_bad = 0;
      address = 3'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      writedata = 32'd0; in_port = 8'hFF; reset = 1'b1;

      //            wr    addr  wdata          pins   out    oe     rd             irq
      vecs[0]  = '{1'b1, 3'd0, 32'hFFFF_FF5A, 8'hFF, 8'h5A, 8'h00, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 3'd4, 32'h0000_0081, 8'hFF, 8'hDB, 8'h00, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b1, 3'd5, 32'h0000_000F, 8'hFF, 8'hD0, 8'h00, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b0, 3'd0, 32'h0,         8'h3C, 8'hD0, 8'h00, 32'h0000_003C, 1'b0};
      vecs[4]  = '{1'b0, 3'd4, 32'h0,         8'h3C, 8'hD0, 8'h00, 32'h0000_0000, 1'b0};
      vecs[5]  = '{1'b1, 3'd1, 32'hFFFF_FFF0, 8'h3C, 8'hD0, 8'hF0, 32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b0, 3'd1, 32'h0,         8'h3C, 8'hD0, 8'hF0, 32'h0000_00F0, 1'b0};
      vecs[7]  = '{1'b1, 3'd1, 32'h0000_0000, 8'h3C, 8'hD0, 8'h00, 32'h0000_00F0, 1'b0};
      vecs[8]  = '{1'b1, 3'd2, 32'hFFFF_FF01, 8'h3C, 8'hD0, 8'h00, 32'h0000_00F0, 1'b0};
      vecs[9]  = '{1'b0, 3'd2, 32'h0,         8'h3C, 8'hD0, 8'h00, 32'h0000_0001, 1'b0};
      vecs[10] = '{1'b0, 3'd3, 32'h0,         8'h3C, 8'hD0, 8'h00, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 8'h3C, 8'hD0, 8'h00, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b1, 3'd4, 32'hFFFF_FF00, 8'h3C, 8'hD0, 8'h00, 32'h0000_0000, 1'b0};
      vecs[13] = '{1'b0, 3'd5, 32'h0,         8'h3C, 8'hD0, 8'h00, 32'h0000_0000, 1'b0};

      // Reset state, pins held high through release.
      idle(3);
      chk("reset out_port", {24'd0, out1}, 32'h0000_00FF);
      chk("reset oe", {24'd0, oe1}, 32'h0);
      chk("reset irq", {31'd0, irq1}, 32'h0);
      chk("reset readdata", rd1, 32'h0);
      @(negedge clk); reset = 1'b0;
      idle(6);
      bus_rd(3'd3);
      chk("warmup edgecap rise", rd1, 32'h0);
      chk("warmup edgecap any", rd2, 32'h0);

      // Register-level vectors.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         in_port = vecs[i].pins;
         idle(3);
         if (vecs[i].is_wr) bus_wr(vecs[i].addr, vecs[i].wdata);
         else               bus_rd(vecs[i].addr);
         chk($sformatf("vec%0d out_port", i), {24'd0, out1}, {24'd0, vecs[i].exp_out});
         chk($sformatf("vec%0d oe", i), {24'd0, oe1}, {24'd0, vecs[i].exp_oe});
         chk($sformatf("vec%0d readdata", i), rd1, vecs[i].exp_rd);
         chk($sformatf("vec%0d irq", i), {31'd0, irq1}, {31'd0, vecs[i].exp_irq});
      end

      // Rising edge on bit 0: irq exactly on the third edge.
      bus_wr(3'd3, 32'h0000_00FF);
      idle(1);
      @(negedge clk); in_port[0] = 1'b1;
      idle(1); chk("rise irq edge N", {31'd0, irq1}, 32'h0);
      idle(1); chk("rise irq edge N+1", {31'd0, irq1}, 32'h0);
      idle(1); chk("rise irq edge N+2", {31'd0, irq1}, 32'h1);
      chk("rise irq any-edge inst", {31'd0, irq2}, 32'h1);
      bus_rd(3'd3);
      chk("rise edgecap", rd1, 32'h0000_0001);

      // Clear, then a falling edge: only the any-edge instance captures.
      bus_wr(3'd3, 32'h0000_0001);
      chk("clear irq", {31'd0, irq1}, 32'h0);
      @(negedge clk); in_port[0] = 1'b0;
      idle(5);
      bus_rd(3'd3);
      chk("fall no capture", rd1, 32'h0);
      chk("fall any capture", rd2, 32'h0000_0001);
      chk("fall irq", {31'd0, irq1}, 32'h0);

      // Set bit 0 again, then collide a new rising edge with its clear.
      @(negedge clk); in_port[0] = 1'b1;
      idle(5);
      chk("pre-collide irq", {31'd0, irq1}, 32'h1);
      @(negedge clk); in_port[0] = 1'b0;
      @(negedge clk); in_port[0] = 1'b1;
      @(negedge clk);
      bus_wr(3'd3, 32'h0000_0001);
      chk("collide irq", {31'd0, irq1}, 32'h1);
      bus_rd(3'd3);
      chk("collide edgecap", rd1, 32'h0000_0001);
      bus_wr(3'd3, 32'h0000_0001);
      chk("reclear irq", {31'd0, irq1}, 32'h0);
      bus_rd(3'd3);
      chk("reclear edgecap", rd1, 32'h0);

      // Output-direction bit does not capture.
      bus_wr(3'd3, 32'h0000_00FF);
      bus_wr(3'd1, 32'h0000_0002);
      chk("dir oe", {24'd0, oe1}, 32'h0000_0002);
      @(negedge clk); in_port[1] = 1'b1;
      idle(5);
      @(negedge clk); in_port[1] = 1'b0;
      idle(5);
      bus_rd(3'd3);
      chk("dir blocks rise", rd1, 32'h0);
      chk("dir blocks any", rd2, 32'h0);
      bus_wr(3'd1, 32'h0000_0000);

      // Any-edge on bit 2: set on first toggle, held after second.
      @(negedge clk); in_port[2] = 1'b0;
      idle(5);
      bus_rd(3'd3);
      chk("any toggle1", rd2, 32'h0000_0004);
      chk("rise toggle1", rd1, 32'h0);
      @(negedge clk); in_port[2] = 1'b1;
      idle(5);
      bus_rd(3'd3);
      chk("any toggle2", rd2, 32'h0000_0004);
      chk("rise toggle2", rd1, 32'h0000_0004);
      bus_wr(3'd2, 32'h0000_0004);
      chk("mask bit2 irq", {31'd0, irq1}, 32'h1);

      // Simultaneous read and write: write performed, read sees old value.
      @(negedge clk);
      address = 3'd1; writedata = 32'h0000_0055;
      chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
      chk("rw oe", {24'd0, oe1}, 32'h0000_0055);
      chk("rw readdata", rd1, 32'h0);

      // Asynchronous reset mid-capture.
      bus_rd(3'd3);
      chk("pre-reset readdata", rd1, 32'h0000_0004);
      @(negedge clk); reset = 1'b1;
      #1;
      chk("async out_port", {24'd0, out1}, 32'h0000_00FF);
      chk("async oe", {24'd0, oe1}, 32'h0);
      chk("async irq", {31'd0, irq1}, 32'h0);
      chk("async readdata", rd1, 32'h0);
      @(negedge clk); reset = 1'b0;
      idle(6);
      bus_rd(3'd7);
      chk("addr7 readdata", rd1, 32'h0);
      bus_rd(3'd3);
      chk("post-reset edgecap", rd1, 32'h0);
      chk("post-reset edgecap any", rd2, 32'h0);
      bus_rd(3'd2);
      chk("post-reset irqmask", rd1, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
